// File: rtl/instruction_fetch_buffer.sv
// Fetch stage: owns the fetch PC, issues word requests to instruction memory and buffers
// returned words with their PC in a small FIFO presented to decode with valid/ready.
module instruction_fetch_buffer #(
    parameter int unsigned             WORD_SIZE    = 32,
    parameter int unsigned             DEPTH        = 2,
    parameter logic [WORD_SIZE-1:0]    RESET_VECTOR = '0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 Redirect,
    input  logic [WORD_SIZE-1:0] RedirectPC,
    output logic                 ImemReq,
    output logic [WORD_SIZE-1:0] ImemAddr,
    input  logic                 ImemGnt,
    input  logic                 ImemRvalid,
    input  logic [WORD_SIZE-1:0] ImemRdata,
    output logic                 InstrValid,
    input  logic                 DecodeReady,
    output logic [WORD_SIZE-1:0] Instr,
    output logic [WORD_SIZE-1:0] PC,
    output logic [WORD_SIZE-1:0] PCp4
);

    localparam int unsigned CW = $clog2(DEPTH + 1) + 1;
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [WORD_SIZE-1:0] NOP_INSTR = WORD_SIZE'(32'h0000_0013);
    localparam logic [WORD_SIZE-1:0] WORD_STEP = WORD_SIZE'(4);
    localparam logic [WORD_SIZE-1:0] ALIGN_MASK = ~WORD_SIZE'(3);

    logic [WORD_SIZE-1:0] fetch_pc_q, fetch_pc_d;
    logic [WORD_SIZE-1:0] resp_pc_q, resp_pc_d;
    logic [CW-1:0]        outstanding_q, outstanding_d;
    logic [CW-1:0]        drop_count_q, drop_count_d;
    logic [CW-1:0]        fifo_count_q, fifo_count_d;
    logic [PW-1:0]        wptr_q, wptr_d;
    logic [PW-1:0]        rptr_q, rptr_d;
    logic [WORD_SIZE-1:0] instr_mem_q [DEPTH];
    logic [WORD_SIZE-1:0] instr_mem_d [DEPTH];
    logic [WORD_SIZE-1:0] pc_mem_q    [DEPTH];
    logic [WORD_SIZE-1:0] pc_mem_d    [DEPTH];

    logic          pop;
    logic          push;
    logic          grant;
    logic [CW-1:0] credit_used;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] ptr);
        return (ptr == PW'(DEPTH - 1)) ? '0 : ptr + PW'(1);
    endfunction

    // Head of FIFO drives decode directly; credit counts in-flight plus buffered words.
    assign InstrValid  = (fifo_count_q != '0);
    assign Instr       = instr_mem_q[rptr_q];
    assign PC          = pc_mem_q[rptr_q];
    assign PCp4        = pc_mem_q[rptr_q] + WORD_STEP;
    assign pop         = InstrValid & DecodeReady;
    assign credit_used = outstanding_q + fifo_count_q - CW'(pop);
    assign ImemReq     = !reset && !Redirect && (credit_used < CW'(DEPTH));
    assign ImemAddr    = fetch_pc_q;
    assign grant       = ImemReq & ImemGnt;

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        resp_pc_d     = resp_pc_q;
        outstanding_d = outstanding_q;
        drop_count_d  = drop_count_q;
        fifo_count_d  = fifo_count_q;
        wptr_d        = wptr_q;
        rptr_d        = rptr_q;
        instr_mem_d   = instr_mem_q;
        pc_mem_d      = pc_mem_q;
        push          = 1'b0;

        if (Redirect) begin
            // Everything still in flight, except a response landing now, must be dropped later.
            fetch_pc_d    = RedirectPC & ALIGN_MASK;
            resp_pc_d     = RedirectPC & ALIGN_MASK;
            fifo_count_d  = '0;
            wptr_d        = '0;
            rptr_d        = '0;
            outstanding_d = outstanding_q - CW'(ImemRvalid);
            drop_count_d  = outstanding_q - CW'(ImemRvalid);
        end else begin
            if (grant) begin
                fetch_pc_d = fetch_pc_q + WORD_STEP;
            end
            if (ImemRvalid) begin
                if (drop_count_q != '0) begin
                    drop_count_d = drop_count_q - CW'(1);
                end else begin
                    push = 1'b1;
                end
            end
            if (push) begin
                instr_mem_d[wptr_q] = ImemRdata;
                pc_mem_d[wptr_q]    = resp_pc_q;
                resp_pc_d           = resp_pc_q + WORD_STEP;
                wptr_d              = ptr_inc(wptr_q);
            end
            if (pop) begin
                rptr_d = ptr_inc(rptr_q);
            end
            fifo_count_d  = fifo_count_q + CW'(push) - CW'(pop);
            outstanding_d = outstanding_q + CW'(grant) - CW'(ImemRvalid);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc_q    <= RESET_VECTOR;
            resp_pc_q     <= RESET_VECTOR;
            outstanding_q <= '0;
            drop_count_q  <= '0;
            fifo_count_q  <= '0;
            wptr_q        <= '0;
            rptr_q        <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                instr_mem_q[i] <= NOP_INSTR;
                pc_mem_q[i]    <= RESET_VECTOR;
            end
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            resp_pc_q     <= resp_pc_d;
            outstanding_q <= outstanding_d;
            drop_count_q  <= drop_count_d;
            fifo_count_q  <= fifo_count_d;
            wptr_q        <= wptr_d;
            rptr_q        <= rptr_d;
            instr_mem_q   <= instr_mem_d;
            pc_mem_q      <= pc_mem_d;
        end
    end

    a_credit: assert property (@(posedge clk) disable iff (reset)
        (outstanding_q + fifo_count_q) <= CW'(DEPTH));
    a_drop: assert property (@(posedge clk) disable iff (reset)
        drop_count_q <= outstanding_q);
    a_rvalid: assert property (@(posedge clk) disable iff (reset)
        !(ImemRvalid && (outstanding_q == '0)));
    a_hold: assert property (@(posedge clk) disable iff (reset)
        (InstrValid && !DecodeReady && !Redirect) |=> ($stable(Instr) && $stable(PC)));

endmodule

// File: tb/tb_instruction_fetch_buffer.sv
// Directed bench for instruction_fetch_buffer: vector table for streaming/stall,
// hand sequences for latency, redirect and wrap/reset corners, with an in-order scoreboard.
module tb_instruction_fetch_buffer;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        reset;
    logic        Redirect;
    logic [31:0] RedirectPC;
    logic        ImemReq;
    logic [31:0] ImemAddr;
    logic        ImemGnt;
    logic        ImemRvalid;
    logic [31:0] ImemRdata;
    logic        InstrValid;
    logic        DecodeReady;
    logic [31:0] Instr;
    logic [31:0] PC;
    logic [31:0] PCp4;

    instruction_fetch_buffer dut (
        .clk(clk), .reset(reset), .Redirect(Redirect), .RedirectPC(RedirectPC),
        .ImemReq(ImemReq), .ImemAddr(ImemAddr), .ImemGnt(ImemGnt),
        .ImemRvalid(ImemRvalid), .ImemRdata(ImemRdata), .InstrValid(InstrValid),
        .DecodeReady(DecodeReady), .Instr(Instr), .PC(PC), .PCp4(PCp4)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        ready;
        logic        req;
        logic [31:0] addr;
        logic        valid;
        logic [31:0] pc;
    } vec_t;

    vec_t        tbl [14];
    int          checks = 0;
    int          passes = 0;
    int          cyc = 0;
    int          lat = 1;
    int          ndeliv = 0;
    int          n0;
    logic [31:0] exp_pc = 32'h0;
    logic [31:0] q_addr [$];
    int          q_due  [$];

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return a * 32'h9E37_79B9 + 32'h5A5A_0001;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Memory model: in-order responses lat cycles after grant, never back-pressured.
    task automatic step();
        if (q_addr.size() > 0 && q_due[0] <= cyc) begin
            ImemRvalid = 1'b1;
            ImemRdata  = mem_data(q_addr[0]);
            void'(q_addr.pop_front());
            void'(q_due.pop_front());
        end else begin
            ImemRvalid = 1'b0;
            ImemRdata  = 32'h0;
        end
        @(negedge clk);
    endtask

    task automatic end_cycle();
        #1;
        if (ImemReq && ImemGnt) begin
            q_addr.push_back(ImemAddr);
            q_due.push_back(cyc + lat);
        end
        if (InstrValid && DecodeReady && !Redirect) begin
            chk("sb_pc", PC, exp_pc);
            chk("sb_instr", Instr, mem_data(exp_pc));
            chk("sb_pcp4", PCp4, exp_pc + 32'd4);
            exp_pc = exp_pc + 32'd4;
            ndeliv++;
        end
        if (Redirect) exp_pc = RedirectPC & 32'hFFFF_FFFC;
        @(posedge clk);
        #1;
        cyc++;
        Redirect = 1'b0;
    endtask

    task automatic do_reset(input int n);
        reset      = 1'b1;
        Redirect   = 1'b0;
        ImemRvalid = 1'b0;
        ImemRdata  = 32'h0;
        q_addr.delete();
        q_due.delete();
        repeat (n) begin
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        chk("rst_req", ImemReq, 1'b0);
        chk("rst_valid", InstrValid, 1'b0);
        chk("rst_instr", Instr, NOP);
        chk("rst_pc", PC, 32'h0);
        chk("rst_pcp4", PCp4, 32'h4);
        @(posedge clk);
        #1;
        reset  = 1'b0;
        cyc    = 0;
        exp_pc = 32'h0;
    endtask

    initial begin
        reset = 1'b1; Redirect = 1'b0; RedirectPC = 32'h0; ImemGnt = 1'b1;
        ImemRvalid = 1'b0; ImemRdata = 32'h0; DecodeReady = 1'b1;

        // Streaming from reset, then a 5-cycle decode stall and release.
        tbl[0]  = '{1'b1, 1'b1, 32'h00, 1'b0, 32'h00};
        tbl[1]  = '{1'b1, 1'b1, 32'h04, 1'b0, 32'h00};
        tbl[2]  = '{1'b1, 1'b1, 32'h08, 1'b1, 32'h00};
        tbl[3]  = '{1'b1, 1'b1, 32'h0C, 1'b1, 32'h04};
        tbl[4]  = '{1'b1, 1'b1, 32'h10, 1'b1, 32'h08};
        tbl[5]  = '{1'b1, 1'b1, 32'h14, 1'b1, 32'h0C};
        tbl[6]  = '{1'b0, 1'b0, 32'h00, 1'b1, 32'h10};
        tbl[7]  = '{1'b0, 1'b0, 32'h00, 1'b1, 32'h10};
        tbl[8]  = '{1'b0, 1'b0, 32'h00, 1'b1, 32'h10};
        tbl[9]  = '{1'b0, 1'b0, 32'h00, 1'b1, 32'h10};
        tbl[10] = '{1'b0, 1'b0, 32'h00, 1'b1, 32'h10};
        tbl[11] = '{1'b1, 1'b1, 32'h18, 1'b1, 32'h10};
        tbl[12] = '{1'b1, 1'b1, 32'h1C, 1'b1, 32'h14};
        tbl[13] = '{1'b1, 1'b1, 32'h20, 1'b1, 32'h18};

        do_reset(3);
        lat = 1;
        for (int i = 0; i < 14; i++) begin
            DecodeReady = tbl[i].ready;
            step();
            chk("tbl_req", ImemReq, tbl[i].req);
            if (tbl[i].req) chk("tbl_addr", ImemAddr, tbl[i].addr);
            chk("tbl_valid", InstrValid, tbl[i].valid);
            chk("tbl_pc", PC, tbl[i].pc);
            chk("tbl_instr", Instr, tbl[i].valid ? mem_data(tbl[i].pc) : NOP);
            chk("tbl_pcp4", PCp4, tbl[i].pc + 32'd4);
            end_cycle();
        end

        // Three-cycle memory: credit limit holds, words arrive in order.
        do_reset(3);
        lat = 3;
        DecodeReady = 1'b1;
        n0 = ndeliv;
        for (int i = 0; i < 40; i++) begin
            chk("t3_outstanding", 32'(q_addr.size() <= 2), 32'd1);
            step();
            end_cycle();
        end
        chk("t3_throughput", 32'((ndeliv - n0) >= 15), 32'd1);

        // Redirect with one word buffered and one request in flight.
        do_reset(3);
        lat = 4;
        DecodeReady = 1'b0;
        step(); chk("t4_req0", ImemAddr, 32'h0); end_cycle();
        ImemGnt = 1'b0;
        step(); chk("t4_req1", ImemReq, 1'b1); end_cycle();
        ImemGnt = 1'b1;
        step(); chk("t4_addr2", ImemAddr, 32'h4); end_cycle();
        step(); chk("t4_full3", ImemReq, 1'b0); end_cycle();
        step(); chk("t4_full4", ImemReq, 1'b0); end_cycle();
        Redirect = 1'b1; RedirectPC = 32'h0000_0100;
        step();
        chk("t4_head", PC, 32'h0);
        chk("t4_redir_req", ImemReq, 1'b0);
        end_cycle();
        step();
        chk("t4_flushed", InstrValid, 1'b0);
        chk("t4_target_addr", ImemAddr, 32'h100);
        end_cycle();
        DecodeReady = 1'b1;
        n0 = ndeliv;
        for (int k = 0; k < 20 && ndeliv == n0; k++) begin
            step();
            end_cycle();
        end
        chk("t4_delivered", 32'(ndeliv > n0), 32'd1);

        // Redirect in the same cycle as a response and a pop.
        do_reset(3);
        lat = 1;
        DecodeReady = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            end_cycle();
        end
        Redirect = 1'b1; RedirectPC = 32'h0000_0200;
        step();
        chk("t5_valid_n", InstrValid, 1'b1);
        chk("t5_req_n", ImemReq, 1'b0);
        end_cycle();
        step();
        chk("t5_valid_n1", InstrValid, 1'b0);
        chk("t5_addr_n1", ImemAddr, 32'h200);
        end_cycle();
        step(); chk("t5_valid_n2", InstrValid, 1'b0); end_cycle();
        step();
        chk("t5_pc_n3", PC, 32'h200);
        chk("t5_instr_n3", Instr, mem_data(32'h200));
        end_cycle();

        // Misaligned redirect near the top of the address space, then reset mid-burst.
        do_reset(3);
        lat = 1;
        Redirect = 1'b1; RedirectPC = 32'hFFFF_FFFE;
        step(); chk("t6_req_n", ImemReq, 1'b0); end_cycle();
        step(); chk("t6_addr_top", ImemAddr, 32'hFFFF_FFFC); end_cycle();
        step(); chk("t6_addr_wrap", ImemAddr, 32'h0); end_cycle();
        step();
        chk("t6_pc_top", PC, 32'hFFFF_FFFC);
        chk("t6_pcp4_wrap", PCp4, 32'h0);
        end_cycle();
        step(); chk("t6_pc_wrap", PC, 32'h0); end_cycle();
        step(); end_cycle();
        do_reset(1);
        step(); chk("t6_restart_addr", ImemAddr, 32'h0); end_cycle();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
